pulse_stretcher: RTL and testbench

- Output-side counterpart to the input conditioning logic: debounced or internal single-cycle events are turned into pulses long enough to be seen on LEDs or sampled by slow external logic.
- Each channel turns a rising edge on its input into an output pulse of exactly HOLD_CYCLES, followed by a forced low gap of GAP_CYCLES.
- Edges that arrive while a channel is busy are queued, so every event stays visible as a distinct pulse.
- Sits between control logic and board-level indicator outputs.

---
 rtl/pulse_stretcher.sv | 149 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Multi-channel pulse stretcher: each input rising edge becomes a HOLD_CYCLES-wide
// pulse followed by a GAP_CYCLES low gap; extra edges are queued. Optional
// feature macro: PULSE_STRETCHER_RETRIGGER_EN (a rise during HOLD extends the pulse).
module pulse_stretcher #(
    parameter int CH          = 4,
    parameter int HOLD_CYCLES = 255,
    parameter int GAP_CYCLES  = 64,
    parameter int CNT_W       = 8,
    parameter int PEND_W      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] out,
    output logic [CH-1:0] busy,
    output logic [CH-1:0] dropped
);

    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [CH-1:0] in_q_r;
    logic [CH-1:0] rise_s;

    // Previous-cycle input sample for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q_r <= {CH{1'b0}};
        end else begin
            in_q_r <= in;
        end
    end

    assign rise_s = in & ~in_q_r;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        state_t            state_r;
        logic [CNT_W-1:0]  cnt_r;
        logic [PEND_W-1:0] pend_r;
        logic              out_r;
        logic              busy_r;
        logic              drop_r;

        // Per-channel HOLD/GAP sequencer with event queue and registered outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
                pend_r  <= PEND_ZERO;
                out_r   <= 1'b0;
                busy_r  <= 1'b0;
                drop_r  <= 1'b0;
            end else begin
                drop_r <= 1'b0;
                case (state_r)
                    ST_IDLE: begin
                        if (rise_s[g]) begin
                            state_r <= ST_HOLD;
                            cnt_r   <= HOLD_LOAD;
                            out_r   <= 1'b1;
                            busy_r  <= 1'b1;
                        end else begin
                            out_r   <= 1'b0;
                            busy_r  <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        busy_r <= 1'b1;
                        if (cnt_r == CNT_ZERO) begin
                            state_r <= ST_GAP;
                            cnt_r   <= GAP_LOAD;
                            out_r   <= 1'b0;
                        end else begin
                            cnt_r   <= cnt_r - CNT_ONE;
                            out_r   <= 1'b1;
                        end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                        // Reload overrides the end-of-hold transition above.
                        if (rise_s[g]) begin
                            state_r <= ST_HOLD;
                            cnt_r   <= HOLD_LOAD;
                            out_r   <= 1'b1;
                        end
`else
                        if (rise_s[g]) begin
                            if (pend_r == PEND_MAX) begin
                                drop_r <= 1'b1;
                            end else begin
                                pend_r <= pend_r + PEND_ONE;
                            end
                        end
`endif
                    end
                    ST_GAP: begin
                        busy_r <= 1'b1;
                        if (cnt_r == CNT_ZERO) begin
                            // A coincident rise replaces the consumed queue slot.
                            if ((pend_r != PEND_ZERO) || rise_s[g]) begin
                                state_r <= ST_HOLD;
                                cnt_r   <= HOLD_LOAD;
                                out_r   <= 1'b1;
                                if (!rise_s[g]) begin
                                    pend_r <= pend_r - PEND_ONE;
                                end
                            end else begin
                                state_r <= ST_IDLE;
                                out_r   <= 1'b0;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                            out_r <= 1'b0;
                            if (rise_s[g]) begin
                                if (pend_r == PEND_MAX) begin
                                    drop_r <= 1'b1;
                                end else begin
                                    pend_r <= pend_r + PEND_ONE;
                                end
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        pend_r  <= PEND_ZERO;
                        out_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end

        assign out[g]     = out_r;
        assign busy[g]    = busy_r;
        assign dropped[g] = drop_r;
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2, CH=4.
// Bit e of each vector is the value at clock edge e after reset release.
module tb_pulse_stretcher;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_s;
    logic [3:0] out_s;
    logic [3:0] busy_s;
    logic [3:0] dropped_s;

    int n_checks = 0;
    int n_pass   = 0;

    pulse_stretcher #(
        .CH(4), .HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8), .PEND_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_s),
        .out(out_s), .busy(busy_s), .dropped(dropped_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r;
        r = 64'd0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Holds reset for two edges with the given input value, checks reset state, releases.
    task automatic do_reset(input logic [3:0] init);
        rst_n = 1'b0;
        in_s  = init;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_eq("reset", {20'd0, out_s, busy_s, dropped_s}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Drives one channel for edges 1..n and compares all outputs of all channels each edge.
    task automatic run_vec(input string name, input int ch, input logic [63:0] in_v,
                           input logic [63:0] out_v, input logic [63:0] busy_v,
                           input logic [63:0] drop_v, input int n);
        logic [11:0] exp_v;
        for (int e = 1; e <= n; e++) begin
            in_s[ch] = in_v[e];
            @(posedge clk);
            #1;
            exp_v = 12'd0;
            exp_v[8 + ch] = out_v[e];
            exp_v[4 + ch] = busy_v[e];
            exp_v[ch]     = drop_v[e];
            check_eq($sformatf("%s e%0d", name, e), {20'd0, out_s, busy_s, dropped_s},
                     {20'd0, exp_v});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_s  = 4'd0;

        do_reset(4'd0);
        run_vec("single", 0, rng(10, 10), rng(10, 13), rng(10, 15), 64'd0, 20);

        do_reset(4'd0);
        run_vec("held", 1, rng(5, 54), rng(5, 8), rng(5, 10), 64'd0, 60);

        do_reset(4'd0);
        run_vec("gap_rise_p0", 0, rng(10, 10) | rng(16, 16),
                rng(10, 13) | rng(16, 19), rng(10, 21), 64'd0, 26);

        do_reset(4'b0100);
        run_vec("high_at_release", 2, rng(1, 10), rng(1, 4), rng(1, 6), 64'd0, 12);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
        do_reset(4'd0);
        run_vec("retrigger", 0, rng(10, 10) | rng(12, 12),
                rng(10, 15), rng(10, 17), 64'd0, 26);
`else
        do_reset(4'd0);
        run_vec("hold_rise", 0, rng(10, 10) | rng(12, 12),
                rng(10, 13) | rng(16, 19), rng(10, 21), 64'd0, 26);

        do_reset(4'd0);
        run_vec("three", 2, rng(10, 10) | rng(12, 12) | rng(14, 14),
                rng(10, 13) | rng(16, 19) | rng(22, 25), rng(10, 27), 64'd0, 32);

        do_reset(4'd0);
        run_vec("saturate", 3,
                rng(10, 10) | rng(12, 12) | rng(14, 14) | rng(16, 16) | rng(18, 18) | rng(20, 20),
                rng(10, 13) | rng(16, 19) | rng(22, 25) | rng(28, 31) | rng(34, 37),
                rng(10, 39), rng(20, 20), 45);

        do_reset(4'd0);
        run_vec("gap_rise_p1", 0, rng(10, 10) | rng(12, 12) | rng(16, 16),
                rng(10, 13) | rng(16, 19) | rng(22, 25), rng(10, 27), 64'd0, 32);

        // Two events still queued while the second pulse is high at edge 17.
        do_reset(4'd0);
        run_vec("pre_reset", 0, rng(10, 10) | rng(12, 12) | rng(14, 14) | rng(16, 16),
                rng(10, 13) | rng(16, 17), rng(10, 17), 64'd0, 17);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", {20'd0, out_s, busy_s, dropped_s}, 32'd0);
        do_reset(4'd0);
        run_vec("post_reset", 0, 64'd0, 64'd0, 64'd0, 64'd0, 30);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
